imul_req_driver: RTL and testbench
==================================

# imul_req_driver

Initiator-side traffic generator and checker for the lab1 integer multiplier val/rdy stream interface. It drives pseudo-random operand pairs into a multiplier's istream, accepts products on its ostream and compares each product against a self-computed expected value. Pass/fail counts are kept per run. It sits opposite the multiplier under test in on-chip self-test and FPGA bring-up builds, replacing the software test source and sink.

## Interface
- NUM_TRANS, 100: transactions per run; range 0..65535.
- SEED, 32'h0000_0001: LFSR reset and restart value; must be nonzero.
- MAX_OUTSTANDING, 4: depth of the expected-product FIFO; power of 2, ≥2.
- STALL_EN, 1: when 1, inject periodic ostream backpressure.

- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- istream_val  out  1  request valid.
- istream_rdy  in  1  multiplier can accept a request.
- istream_msg  out  64  {a[31:0], b[31:0]}.
- ostream_val  in  1  product valid.
- ostream_rdy  out  1  driver can accept a product.
- ostream_msg  in  32  product.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  run complete; held until the next start.
- err  out  1  sticky; set on any mismatch, cleared on start.
- pass_count  out  16  matching responses this run.
- fail_count  out  16  mismatching responses this run.

## Operation
- States:
  - IDLE → RUN on start.
  - RUN → DRAIN when issued==NUM_TRANS.
  - DRAIN → DONE when received==NUM_TRANS.
  - DONE → RUN on start.
  - With NUM_TRANS=0, start moves IDLE/DONE → DONE directly.
- start in IDLE/DONE also clears counters, err, issued and received, resets the FIFO pointers, and loads lfsr with SEED. start in RUN/DRAIN is ignored.
- LFSR (32-bit Galois): step(x) = (x>>1) ^ (x[0] ? 32'h8020_0003 : 0).
  - a = lfsr, b = step(lfsr).
  - On each istream fire, lfsr ← step(step(lfsr)).
- istream_val = RUN && !fifo_full.
- istream_msg = istream_val ? {a,b} : 64'd0.
- istream_val, once high, stays high with a stable msg until fire. This holds by construction: the FIFO cannot fill without a fire, and RUN cannot exit without a fire.
- Fire means val && rdy at posedge. An istream fire pushes (a*b)[31:0] to the FIFO and increments issued.
- ostream_rdy = (RUN||DRAIN) && !fifo_empty && !(STALL_EN && cyc[1:0]==2'b11).
  - cyc is a free-running 2-bit counter, reset to 0.
- An ostream fire pops the FIFO head and compares it with ostream_msg. On match, pass_count++; otherwise fail_count++ and err←1. received increments on every ostream fire.
- Push and pop in the same cycle are both legal. A push is never attempted when full. A pop is never possible when empty.
- All arithmetic is modulo 2^32. Counters are 16-bit and do not saturate, since they cannot exceed NUM_TRANS.

## Timing
- Reset values: istream_val=0, istream_msg=0, ostream_rdy=0, busy=0, done=0, err=0, pass_count=0, fail_count=0.
- Reset internal values: state=IDLE, lfsr=SEED, FIFO empty.
- Reset is asynchronous mid-run. Everything returns to reset values immediately, and any in-flight responses are dropped.
- istream_val rises in the first RUN cycle, one cycle after the start edge.
- Back-to-back issue is allowed: 1 request per cycle while istream_rdy=1 and the FIFO is not full.
- Counters and err update at the ostream fire edge.
- done and the DONE state assert in the cycle after the final ostream fire. busy falls in the same cycle.
- With NUM_TRANS=0, done asserts one cycle after start.

## Test plan
- Ideal 1-cycle responder, SEED=1, NUM_TRANS=4.
  - First istream_msg = {32'h0000_0001, 32'h8020_0003}.
  - Expected result: pass=4, fail=0, err=0, done=1.
- Responder inverts ostream_msg[0] on responses 2 and 4, NUM_TRANS=4 → pass=2, fail=2, err=1.
- istream_rdy held low for 10 cycles after start → istream_val stays 1 and msg stays {1, 32'h8020_0003} for all 10 cycles. Exactly one push occurs when rdy rises.
- Responder accepts every request but withholds all responses, MAX_OUTSTANDING=4 → istream_val drops after 4 fires. Releasing one response re-enables issue on the next cycle.
- STALL_EN=1, responder always valid → ostream_rdy is low whenever cyc==3 and no fire occurs then. Final counts are unchanged versus STALL_EN=0.
- Reset asserted after 2 completed transactions → all outputs return to reset values. A new start reproduces first msg {1, 32'h8020_0003}.
- NUM_TRANS=0 → done=1 one cycle after start, with istream_val never asserted and counts 0.

Source files
------------

// File: rtl/imul_req_driver.sv
// imul_req_driver: traffic generator and checker for a val/rdy integer multiplier.
// Issues LFSR-derived operand pairs and keeps the expected products in a small FIFO.
// Each returned product is scored against the FIFO head.
module imul_req_driver #(
  parameter int unsigned NUM_TRANS       = 100,
  parameter logic [31:0] SEED            = 32'h0000_0001,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          STALL_EN        = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        istream_val,
  input  logic        istream_rdy,
  output logic [63:0] istream_msg,
  input  logic        ostream_val,
  output logic        ostream_rdy,
  input  logic [31:0] ostream_msg,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count
);

  localparam int unsigned CW    = 16;
  localparam int unsigned AW    = $clog2(MAX_OUTSTANDING);
  localparam int unsigned PW    = AW + 1;
  localparam logic [CW-1:0] LAST  = CW'(NUM_TRANS);
  localparam logic [PW-1:0] DEPTH = PW'(MAX_OUTSTANDING);
  localparam logic [31:0]   POLY  = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_d;
  logic [31:0]   lfsr, lfsr_b, prod;
  logic [CW-1:0] issued, received;
  logic [PW-1:0] wr_ptr, rd_ptr, fill;
  logic [31:0]   mem [MAX_OUTSTANDING];
  logic [1:0]    cyc;
  logic          fifo_full, fifo_empty, start_ok, in_fire, out_fire, match;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? POLY : 32'h0);
  endfunction

  // Operand/product generation and FIFO status.
  assign lfsr_b     = lfsr_step(lfsr);
  assign prod       = lfsr * lfsr_b;
  assign fill       = wr_ptr - rd_ptr;
  assign fifo_full  = (fill == DEPTH);
  assign fifo_empty = (fill == '0);
  assign match      = (ostream_msg == mem[rd_ptr[AW-1:0]]);

  // Handshake outputs decoded from registered state only.
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);
  assign istream_val = (state == RUN) && !fifo_full;
  assign istream_msg = istream_val ? {lfsr, lfsr_b} : 64'd0;
  assign ostream_rdy = busy && !fifo_empty && !(STALL_EN && (cyc == 2'b11));

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign in_fire  = istream_val && istream_rdy;
  assign out_fire = ostream_val && ostream_rdy;

  // Next-state logic; RUN and DRAIN exit on the fire that completes the count.
  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: if (start) state_d = (NUM_TRANS == 0) ? DONE : RUN;
      RUN:        if (in_fire && ((issued + 16'd1) == LAST)) state_d = DRAIN;
      DRAIN:      if (out_fire && ((received + 16'd1) == LAST)) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // LFSR, counters, FIFO pointers and scoreboard results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr       <= SEED;
      issued     <= '0;
      received   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cyc        <= '0;
      pass_count <= '0;
      fail_count <= '0;
      err        <= 1'b0;
    end else begin
      cyc <= cyc + 2'd1;
      if (start_ok) begin
        lfsr       <= SEED;
        issued     <= '0;
        received   <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        pass_count <= '0;
        fail_count <= '0;
        err        <= 1'b0;
      end else begin
        if (in_fire) begin
          lfsr   <= lfsr_step(lfsr_b);
          issued <= issued + 16'd1;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (out_fire) begin
          rd_ptr   <= rd_ptr + PW'(1);
          received <= received + 16'd1;
          if (match) begin
            pass_count <= pass_count + 16'd1;
          end else begin
            fail_count <= fail_count + 16'd1;
            err        <= 1'b1;
          end
        end
      end
    end
  end

  // Expected-product storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_ptr[AW-1:0]] <= prod;
  end

endmodule

// File: tb/tb_imul_req_driver.sv
// Randomized bench for imul_req_driver with a queue-based behavioural model.
module tb_imul_req_driver;

  localparam int NT    = 6;
  localparam int DEPTH = 4;
  localparam logic [31:0] SEED       = 32'h0000_0001;
  localparam logic [63:0] FIRST_MSG  = {32'h0000_0001, 32'h8020_0003};
  localparam logic [63:0] SECOND_MSG = {32'hC030_0002, 32'h6018_0001};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        istream_rdy = 1'b0;
  logic        ostream_val = 1'b0;
  logic [31:0] ostream_msg = 32'd0;
  logic        istream_val, ostream_rdy, busy, done, err;
  logic [63:0] istream_msg;
  logic [15:0] pass_count, fail_count;

  logic        z_start = 1'b0;
  logic        z_ival, z_ordy, z_busy, z_done, z_err;
  logic [63:0] z_msg;
  logic [15:0] z_pass, z_fail;

  always #5 clk = ~clk;

  imul_req_driver #(.NUM_TRANS(NT), .SEED(SEED), .MAX_OUTSTANDING(DEPTH), .STALL_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .istream_val(istream_val), .istream_rdy(istream_rdy), .istream_msg(istream_msg),
    .ostream_val(ostream_val), .ostream_rdy(ostream_rdy), .ostream_msg(ostream_msg),
    .busy(busy), .done(done), .err(err), .pass_count(pass_count), .fail_count(fail_count)
  );

  imul_req_driver #(.NUM_TRANS(0), .SEED(SEED), .MAX_OUTSTANDING(DEPTH), .STALL_EN(1'b1)) u_zero (
    .clk(clk), .reset(reset), .start(z_start),
    .istream_val(z_ival), .istream_rdy(1'b1), .istream_msg(z_msg),
    .ostream_val(1'b0), .ostream_rdy(z_ordy), .ostream_msg(32'd0),
    .busy(z_busy), .done(z_done), .err(z_err), .pass_count(z_pass), .fail_count(z_fail)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [31:0] m_lfsr = SEED;
  logic [31:0] m_q[$];
  int m_issued = 0, m_received = 0, m_pass = 0, m_fail = 0, m_cyc = 0;
  bit m_err = 1'b0, m_active = 1'b0, m_done = 1'b0;

  // Responder state
  logic [31:0] r_q[$];
  int r_sent = 0;
  int rdy_pct = 100, val_pct = 100, allow = -1;
  bit corrupt = 1'b0;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic bit exp_ival();
    return m_active && (m_issued < NT) && (m_q.size() < DEPTH);
  endfunction

  function automatic bit exp_ordy();
    return m_active && (m_q.size() > 0) && ((m_cyc % 4) != 3);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED; m_q.delete();
    m_issued = 0; m_received = 0; m_pass = 0; m_fail = 0;
    m_err = 1'b0;
  endtask

  task automatic compare_all();
    bit ev;
    ev = exp_ival();
    chk("istream_val", 64'(istream_val), 64'(ev));
    chk("istream_msg", istream_msg, ev ? {m_lfsr, lfsr_step(m_lfsr)} : 64'd0);
    chk("ostream_rdy", 64'(ostream_rdy), 64'(exp_ordy()));
    chk("busy", 64'(busy), 64'(m_active));
    chk("done", 64'(done), 64'(m_done));
    chk("err", 64'(err), 64'(m_err));
    chk("pass_count", 64'(pass_count), 64'(m_pass));
    chk("fail_count", 64'(fail_count), 64'(m_fail));
    if ((m_cyc % 4) == 3) chk("stall_rdy", 64'(ostream_rdy), 64'd0);
  endtask

  // One clock: check outputs, drive inputs for the coming edge, advance model and responder.
  task automatic step_cycle(input bit do_start);
    bit e_ival, e_ordy, in_f, out_f;
    logic [31:0] flip, head, p;
    compare_all();
    e_ival = exp_ival();
    e_ordy = exp_ordy();
    start = do_start;
    istream_rdy = ($urandom_range(99) < rdy_pct);
    ostream_val = (r_q.size() > 0) && (allow != 0) && ($urandom_range(99) < val_pct);
    flip = (corrupt && (r_sent == 1 || r_sent == 3)) ? 32'd1 : 32'd0;
    ostream_msg = ostream_val ? (r_q[0] ^ flip) : 32'd0;
    if (do_start && !m_active) begin
      r_q.delete(); r_sent = 0;
    end
    if (istream_val && istream_rdy) begin
      p = istream_msg[63:32] * istream_msg[31:0];
      r_q.push_back(p);
    end
    if (ostream_val && ostream_rdy) begin
      void'(r_q.pop_front());
      r_sent++;
      if (allow > 0) allow--;
    end
    in_f  = e_ival && istream_rdy;
    out_f = e_ordy && ostream_val;
    if (do_start && !m_active) begin
      model_reset();
      m_active = (NT > 0);
      m_done   = (NT == 0);
    end else begin
      if (in_f) begin
        p = m_lfsr * lfsr_step(m_lfsr);
        m_q.push_back(p);
        m_issued++;
        m_lfsr = lfsr_step(lfsr_step(m_lfsr));
      end
      if (out_f) begin
        head = m_q.pop_front();
        if (head == ostream_msg) m_pass++;
        else begin m_fail++; m_err = 1'b1; end
        m_received++;
        if (m_received == NT) begin m_active = 1'b0; m_done = 1'b1; end
      end
    end
    m_cyc++;
    @(negedge clk);
  endtask

  task automatic finish_run(input string tag);
    int budget;
    budget = 500;
    while (!m_done && budget > 0) begin
      step_cycle(($urandom_range(99) < 3) ? 1'b1 : 1'b0);
      budget--;
    end
    if (!m_done) begin
      n_vec++; n_bad++;
      $display("FAIL %s_timeout: done=%0b, want 1 within 500 cycles", tag, done);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b0; start = 1'b0; istream_rdy = 1'b0; ostream_val = 1'b0; ostream_msg = 32'd0;
    model_reset(); m_active = 1'b0; m_done = 1'b0; m_cyc = 0;
    r_q.delete(); r_sent = 0; allow = -1;
    #1;
    chk("rst_ival", 64'(istream_val), 64'd0);
    chk("rst_msg", istream_msg, 64'd0);
    chk("rst_ordy", 64'(ostream_rdy), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_pass", 64'(pass_count), 64'd0);
    chk("rst_fail", 64'(fail_count), 64'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    do_reset();

    // Ideal responder
    rdy_pct = 100; val_pct = 100; corrupt = 1'b0;
    step_cycle(1'b1);
    chk("first_msg", istream_msg, FIRST_MSG);
    finish_run("ideal");
    chk("ideal_pass", 64'(pass_count), 64'd6);
    chk("ideal_fail", 64'(fail_count), 64'd0);
    chk("ideal_err", 64'(err), 64'd0);
    chk("ideal_done", 64'(done), 64'd1);

    // Corrupt responses 2 and 4
    corrupt = 1'b1;
    step_cycle(1'b1);
    finish_run("corrupt");
    chk("corrupt_pass", 64'(pass_count), 64'd4);
    chk("corrupt_fail", 64'(fail_count), 64'd2);
    chk("corrupt_err", 64'(err), 64'd1);
    corrupt = 1'b0;

    // istream_rdy low for 10 cycles: request must hold
    rdy_pct = 0;
    step_cycle(1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_val", 64'(istream_val), 64'd1);
      chk("hold_msg", istream_msg, FIRST_MSG);
      step_cycle(1'b0);
    end
    rdy_pct = 100;
    step_cycle(1'b0);
    rdy_pct = 0;
    chk("one_push_msg", istream_msg, SECOND_MSG);
    rdy_pct = 100;
    finish_run("hold");

    // Withhold all responses: FIFO fills, then one release re-enables issue
    allow = 0;
    step_cycle(1'b1);
    repeat (8) step_cycle(1'b0);
    chk("full_val_low", 64'(istream_val), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    allow = 1;
    k = 0;
    while (allow != 0 && k < 10) begin step_cycle(1'b0); k++; end
    chk("reissue_val", 64'(istream_val), 64'd1);
    allow = -1;
    finish_run("withhold");

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      rdy_pct = 30 + int'($urandom_range(70));
      val_pct = 30 + int'($urandom_range(70));
      corrupt = ($urandom_range(1) == 1);
      step_cycle(1'b1);
      finish_run("random");
      chk("random_total", 64'(pass_count) + 64'(fail_count), 64'd6);
    end
    rdy_pct = 100; val_pct = 100; corrupt = 1'b0;

    // Reset mid-run after 2 completed transactions
    step_cycle(1'b1);
    k = 0;
    while (m_received < 2 && k < 50) begin step_cycle(1'b0); k++; end
    do_reset();
    step_cycle(1'b1);
    chk("restart_first_msg", istream_msg, FIRST_MSG);
    finish_run("restart");
    chk("restart_pass", 64'(pass_count), 64'd6);

    // NUM_TRANS = 0 instance
    chk("zero_idle_done", 64'(z_done), 64'd0);
    z_start = 1'b1;
    @(negedge clk);
    z_start = 1'b0;
    chk("zero_done", 64'(z_done), 64'd1);
    chk("zero_busy", 64'(z_busy), 64'd0);
    chk("zero_pass", 64'(z_pass), 64'd0);
    chk("zero_fail", 64'(z_fail), 64'd0);
    chk("zero_err", 64'(z_err), 64'd0);
    repeat (3) begin
      chk("zero_ival", 64'(z_ival), 64'd0);
      chk("zero_ordy", 64'(z_ordy), 64'd0);
      chk("zero_msg", z_msg, 64'd0);
      chk("zero_hold_done", 64'(z_done), 64'd1);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
